// File: rtl/sprite_compositor_if.sv
// Drawing bus between the bitmap blocks / VGA scan side and the compositor.
// The master drives per-pixel layer requests and receives the composited pixel
// and the per-frame collision report; the compositor sits on the slave side.
interface sprite_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 12
);
    localparam int SEL_W = $clog2(NUM_LAYERS) + 1;

    logic                             startOfFrame;
    logic                             pixelValid;
    logic [NUM_LAYERS-1:0]            drawingRequest;
    logic [NUM_LAYERS-1:0][7:0]       RGBin;
    logic [7:0]                       backGroundRGB;
    logic [7:0]                       RGBout;
    logic [SEL_W-1:0]                 layerSel;
    logic                             collisionValid;
    logic [NUM_LAYERS-1:0]            collisionMask;
    logic [CNT_W-1:0]                 overlapCount;

    modport master (
        output startOfFrame, pixelValid, drawingRequest, RGBin, backGroundRGB,
        input  RGBout, layerSel, collisionValid, collisionMask, overlapCount
    );

    modport slave (
        input  startOfFrame, pixelValid, drawingRequest, RGBin, backGroundRGB,
        output RGBout, layerSel, collisionValid, collisionMask, overlapCount
    );
endinterface

// File: rtl/sprite_compositor.sv
// Fixed-priority sprite compositor: layer 0 is frontmost. Produces a registered
// pixel stream plus a per-frame report of which layers overlapped and how many
// overlap pixels occurred (saturating). Reports describe the frame just closed.
module sprite_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 12
) (
    input  logic               clk,
    input  logic               reset,
    sprite_compositor_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_LAYERS) + 1;

    typedef enum logic {WAIT_SOF, RUN} state_t;

    state_t                state, state_nxt;
    logic [NUM_LAYERS-1:0] req;
    logic                  overlap;
    logic [7:0]            win_rgb;
    logic [SEL_W-1:0]      win_sel;
    logic [7:0]            rgb_q;
    logic [SEL_W-1:0]      sel_q;
    logic                  acc_reload, acc_step, report;
    logic [NUM_LAYERS-1:0] acc_mask, rep_mask;
    logic [CNT_W-1:0]      acc_cnt, rep_cnt;
    logic                  rep_valid;

    assign req = bus.drawingRequest;
    // Two or more requests: clearing the lowest set bit leaves something behind.
    assign overlap = bus.pixelValid && ((req & (req - NUM_LAYERS'(1))) != '0);

    // Priority pick: scan back to front so the lowest requesting index wins.
    always_comb begin
        win_rgb = bus.backGroundRGB;
        win_sel = SEL_W'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_rgb = bus.RGBin[i];
                win_sel = SEL_W'(i);
            end
        end
    end

    // Output pixel register; blanking forces black and the background index.
    always_ff @(posedge clk) begin
        if (reset || !bus.pixelValid) begin
            rgb_q <= 8'h00;
            sel_q <= SEL_W'(NUM_LAYERS);
        end else begin
            rgb_q <= win_rgb;
            sel_q <= win_sel;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_SOF;
        else       state <= state_nxt;
    end

    // Next state: the first SOF after reset arms accumulation for good.
    always_comb begin
        state_nxt = state;
        if (state == WAIT_SOF && bus.startOfFrame) state_nxt = RUN;
    end

    // FSM outputs: SOF always restarts the accumulator with its own pixel;
    // only an SOF seen while running closes a frame worth reporting.
    always_comb begin
        acc_reload = bus.startOfFrame;
        report     = (state == RUN) && bus.startOfFrame;
        acc_step   = (state == RUN) && !bus.startOfFrame;
    end

    // Per-frame overlap accumulator with saturating pixel count.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_mask <= '0;
            acc_cnt  <= '0;
        end else if (acc_reload) begin
            acc_mask <= overlap ? req : '0;
            acc_cnt  <= overlap ? CNT_W'(1) : '0;
        end else if (acc_step && overlap) begin
            acc_mask <= acc_mask | req;
            if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    // Report registers: one-cycle valid pulse, values held until the next report.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_valid <= 1'b0;
            rep_mask  <= '0;
            rep_cnt   <= '0;
        end else begin
            rep_valid <= report;
            if (report) begin
                rep_mask <= acc_mask;
                rep_cnt  <= acc_cnt;
            end
        end
    end

    assign bus.RGBout         = rgb_q;
    assign bus.layerSel       = sel_q;
    assign bus.collisionValid = rep_valid;
    assign bus.collisionMask  = rep_mask;
    assign bus.overlapCount   = rep_cnt;
endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios followed by
// random pixel traffic, all compared against a frame-level reference model.
module tb_sprite_compositor;
    localparam int NL  = 4;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state.
    bit       started;
    bit [3:0] m_mask;
    int       m_cnt;
    bit [3:0] h_mask;
    int       h_cnt;

    sprite_compositor_if #(.NUM_LAYERS(NL), .CNT_W(CW)) bus ();

    sprite_compositor #(.NUM_LAYERS(NL), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one pixel, advance one clock, check every output against the model.
    task automatic step(input logic sof, input logic pv, input logic [3:0] req,
                        input logic [31:0] rgb, input logic [7:0] bg, input logic rst = 1'b0);
        logic [7:0] e_rgb;
        int         e_sel;
        bit         e_valid;
        reset              = rst;
        bus.startOfFrame   = sof;
        bus.pixelValid     = pv;
        bus.drawingRequest = req;
        bus.RGBin          = rgb;
        bus.backGroundRGB  = bg;

        e_rgb = 8'h00;
        e_sel = NL;
        e_valid = 1'b0;
        if (rst) begin
            started = 0; m_mask = 0; m_cnt = 0; h_mask = 0; h_cnt = 0;
        end else begin
            if (pv) begin
                e_rgb = bg;
                for (int i = 0; i < NL; i++) begin
                    if (req[i]) begin
                        e_rgb = rgb[i*8 +: 8];
                        e_sel = i;
                        break;
                    end
                end
            end
            e_valid = started && sof;
            if (e_valid) begin
                h_mask = m_mask;
                h_cnt  = (m_cnt > MAX) ? MAX : m_cnt;
            end
            if (sof) begin
                started = 1; m_mask = 0; m_cnt = 0;
            end
            if (started && pv && $countones(req) >= 2) begin
                m_mask |= req;
                m_cnt++;
            end
        end

        @(posedge clk);
        #1;
        chk("rgb",   bus.RGBout,         e_rgb);
        chk("sel",   bus.layerSel,       e_sel);
        chk("valid", bus.collisionValid, e_valid);
        chk("mask",  bus.collisionMask,  h_mask);
        chk("count", bus.overlapCount,   h_cnt);
    endtask

    initial begin
        reset = 1'b1;
        bus.startOfFrame = 0; bus.pixelValid = 0; bus.drawingRequest = 0;
        bus.RGBin = '0; bus.backGroundRGB = 0;
        step(0, 1, 4'b1111, 32'hFFFFFFFF, 8'hFF, 1);
        step(0, 0, 4'b0000, 32'h0, 8'h00, 1);

        // Priority and background
        step(0, 1, 4'b0110, 32'h11448C22, 8'h25);
        chk("t1_rgb", bus.RGBout, 8'h8C);
        chk("t1_sel", bus.layerSel, 3'd1);
        step(0, 1, 4'b0000, 32'h11448C22, 8'h25);
        chk("t1_bg", bus.RGBout, 8'h25);
        // Blanking
        step(0, 0, 4'b0001, 32'h000000AA, 8'h25);

        // First frame overlaps before any SOF are ignored
        repeat (3) step(0, 1, 4'b1100, 32'h01020304, 8'h10);
        // Collision frame
        step(1, 1, 4'b0000, 32'h0, 8'h10);
        repeat (5) step(0, 1, 4'b1001, 32'hA0B0C0D0, 8'h10);
        repeat (3) step(0, 1, 4'b0100, 32'hA0B0C0D0, 8'h10);
        step(0, 0, 4'b1111, 32'h0, 8'h10);
        step(1, 1, 4'b0000, 32'h0, 8'h10);
        chk("t3_valid", bus.collisionValid, 1'b1);
        chk("t3_mask",  bus.collisionMask, 4'b1001);
        chk("t3_count", bus.overlapCount, 4'd5);
        step(0, 1, 4'b0001, 32'h0, 8'h10);
        chk("t3_pulse", bus.collisionValid, 1'b0);
        // Empty frame
        repeat (4) step(0, 1, 4'b0010, 32'h0, 8'h10);
        step(1, 1, 4'b0011, 32'h0, 8'h10);   // SOF pixel belongs to new frame
        chk("t3_empty", bus.overlapCount, 4'd0);
        step(0, 1, 4'b0000, 32'h0, 8'h10);
        step(1, 1, 4'b0000, 32'h0, 8'h10);
        chk("t5_mask", bus.collisionMask, 4'b0011);
        // Back-to-back SOF
        step(1, 1, 4'b0101, 32'h0, 8'h10);
        step(1, 1, 4'b0000, 32'h0, 8'h10);
        // Saturation
        repeat (20) step(0, 1, 4'b1110, 32'h0, 8'h10);
        step(1, 1, 4'b0000, 32'h0, 8'h10);
        chk("t5_sat", bus.overlapCount, 4'd15);
        // Reset mid-frame, then first SOF gives no report
        repeat (3) step(0, 1, 4'b0011, 32'h0, 8'h10);
        step(0, 1, 4'b0011, 32'h0, 8'h10, 1);
        step(1, 1, 4'b0000, 32'h0, 8'h10);
        chk("t6_nosof", bus.collisionValid, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic       sof, pv, rst;
            logic [3:0] req;
            sof = ($urandom_range(0, 19) == 0);
            pv  = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 499) == 0);
            req = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            step(sof, pv, req, $urandom, 8'($urandom), rst);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
